rrb_req_agent: RTL and testbench
================================

Name: rrb_req_agent

Overview:
- Requester-side front end for the 4-channel round-robin arbiter (rrb).
- Per channel, it queues request events in a saturating pending counter and drives the arbiter's `req` lines.
- It consumes one-hot single-cycle grants, emits one dispatch pulse per accepted grant with the channel index, and flags starvation and protocol errors.

Parameters:
- CNT_W, 3: width of each channel's pending counter; max pending per channel = 2^CNT_W-1 (7).
- WDOG_LIM, 12: number of consecutive cycles a channel may request without a grant before starve_o is raised (1..255).

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_ni  input  1  asynchronous active-low reset
- push_i  input  4  per-channel request event; bit c adds one pending request to channel c
- push_ready_o  output  4  bit c high when channel c counter < 2^CNT_W-1
- req_o  output  4  to arbiter req_i; bit c = (pend[c] != 0)
- grant_i  input  4  from arbiter grant_o; expected one-hot, 1-cycle pulses
- disp_valid_o  output  1  one-cycle pulse per accepted grant
- disp_id_o  output  2  channel index of the dispatch, valid with disp_valid_o
- starve_o  output  4  bit c high while channel c wait counter == WDOG_LIM
- err_o  output  3  sticky: [0] push overflow, [1] grant to idle channel, [2] multi-hot grant
- err_clr_i  input  1  synchronous clear of err_o

Behaviour:
Reset (rst_ni low, asynchronous):
- pend[*]=0, wait[*]=0.
- req_o=0, push_ready_o=4'b1111 (combinational from pend), disp_valid_o=0, disp_id_o=0, starve_o=0, err_o=0.
- Reset mid-operation discards all pending requests. No dispatch is produced for a grant arriving in the cycle reset deasserts.

Pending counters, per channel c, evaluated each cycle:
- inc = push_i[c].
- dec = grant accepted on c. A grant is accepted when grant_i is one-hot, grant_i[c]=1 and pend[c]!=0.
- inc & ~dec: pend+1 if not full; if full, the push is dropped and err_o[0] is set.
- dec & ~inc: pend-1.
- inc & dec: pend unchanged. This holds even when full; a push is never dropped when it coincides with an accepted grant.
- No wrap-around in either direction.

Request output:
- req_o is combinational from registered pend, so it changes the cycle after the counter update.
- rrb grants one cycle after sampling req and returns to IDLE between grants. The agent keeps req high while pending; it must not try to hide the grant-cycle request.

Dispatch:
- An accepted grant in cycle t produces disp_valid_o=1 and disp_id_o=c in cycle t+1.
- disp_id_o holds its last value when disp_valid_o=0.

Error cases (err_o is sticky, cleared only by err_clr_i or reset):
- grant_i one-hot on a channel with pend==0: no decrement, no dispatch, err_o[1] set.
- grant_i with more than one bit set: whole grant ignored, err_o[2] set.
- grant_i == 0: no action.
- err_clr_i together with a new error in the same cycle: the new error wins, so its bit is set.

Watchdog, per channel:
- wait[c] resets to 0 when req_o[c]=0 or a grant is accepted on c.
- Otherwise it increments, saturating at WDOG_LIM.
- starve_o[c] = (wait[c]==WDOG_LIM). It deasserts the cycle after the grant is accepted.

Test Plan:
- Single request: after reset, push_i=4'b0001 for 1 cycle → req_o=0001 next cycle. Drive grant_i=0001 for 1 cycle → disp_valid_o=1, disp_id_o=0 one cycle later; req_o returns to 0000.
- Full and overflow: push ch2 eight consecutive cycles, no grant → pend[2]=7, push_ready_o[2]=0 after the 7th, err_o=3'b001 after the 8th. Then grant ch2 seven times → exactly 7 dispatches with id 2, req_o[2]=0 afterwards.
- Simultaneous events: pend[1]=7 (full); push_i[1] and grant_i[1] in the same cycle → pend[1] stays 7, err_o[0] stays 0, one dispatch with id 1.
- Bad grants: grant_i=0100 with pend[2]=0 → no dispatch, err_o[1]=1. grant_i=0011 with pend[0]=pend[1]=1 → no dispatch, counters unchanged, err_o[2]=1. Pulse err_clr_i → err_o=000.
- Starvation: push ch3 once, withhold grants → starve_o[3]=1 exactly WDOG_LIM (12) cycles after req_o[3] rises. grant_i=1000 → starve_o[3]=0 next cycle.
- Integration with rrb: push all four channels twice each → 8 dispatches, disp_id_o sequence 0,1,2,3,0,1,2,3, spaced 2 cycles apart; err_o remains 000. Assert rst_ni low mid-sequence → all outputs return to reset values immediately, with no further dispatches.

Source files
------------

// File: rtl/rrb_req_agent.sv
// rrb_req_agent: requester-side front end for the 4-channel round-robin arbiter.
// Latency: push -> req_o next cycle; accepted grant -> disp_valid_o/disp_id_o next cycle.
// Backpressure: push_ready_o[c] drops while channel c holds 2^CNT_W-1 pending; pushes to a full channel are dropped and flagged.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i[3:0]            per-channel request event (adds one pending request)
//   push_ready_o[3:0]      channel counter not full
//   req_o[3:0]             request lines to the arbiter (pending != 0)
//   grant_i[3:0]           one-hot single-cycle grants from the arbiter
//   disp_valid_o           one-cycle pulse per accepted grant
//   disp_id_o[1:0]         channel of the dispatch, held between pulses
//   starve_o[3:0]          channel has waited WDOG_LIM cycles without a grant
//   err_o[2:0]             sticky: [0] push overflow, [1] grant to idle channel, [2] multi-hot grant
//   err_clr_i              synchronous clear of err_o (a same-cycle new error still sets its bit)
module rrb_req_agent #(
  parameter int CNT_W    = 3,
  parameter int WDOG_LIM = 12
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] push_i,
  output logic [3:0] push_ready_o,
  output logic [3:0] req_o,
  input  logic [3:0] grant_i,
  output logic       disp_valid_o,
  output logic [1:0] disp_id_o,
  output logic [3:0] starve_o,
  output logic [2:0] err_o,
  input  logic       err_clr_i
);

  localparam int               NCH      = 4;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
  localparam logic [7:0]       WAIT_LIM = 8'(WDOG_LIM);
  localparam logic [7:0]       WAIT_ONE = 8'(1);

  logic [CNT_W-1:0] pend_q [NCH];
  logic [7:0]       wait_q [NCH];
  logic [2:0]       err_q;
  logic             disp_valid_q;
  logic [1:0]       disp_id_q;

  logic [3:0] pend_nz;
  logic [3:0] pend_full;
  logic [3:0] acc;
  logic [1:0] acc_id;
  logic       grant_onehot;
  logic       grant_multi;
  logic [2:0] err_new;

  // A grant with more than one bit set is discarded as a whole, so acceptance
  // is only possible when exactly one bit is high.
  always_comb begin
    grant_onehot = (grant_i != 4'd0) && ((grant_i & (grant_i - 4'd1)) == 4'd0);
    grant_multi  = (grant_i != 4'd0) && !grant_onehot;
  end

  always_comb begin
    pend_nz   = '0;
    pend_full = '0;
    acc       = '0;
    acc_id    = '0;
    for (int c = 0; c < NCH; c++) begin
      pend_nz[c]   = (pend_q[c] != '0);
      pend_full[c] = (pend_q[c] == PEND_MAX);
      acc[c]       = grant_onehot && grant_i[c] && pend_nz[c];
      if (acc[c]) acc_id = 2'(c);
    end
  end

  // A push into a full counter only overflows when no grant frees a slot in
  // the same cycle.
  always_comb begin
    err_new    = '0;
    err_new[0] = |(push_i & ~acc & pend_full);
    err_new[1] = grant_onehot && ((grant_i & pend_nz) == 4'd0);
    err_new[2] = grant_multi;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NCH; c++) begin
        pend_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push_i[c] && !acc[c] && !pend_full[c]) begin
          pend_q[c] <= pend_q[c] + PEND_ONE;
        end else if (acc[c] && !push_i[c]) begin
          pend_q[c] <= pend_q[c] - PEND_ONE;
        end
      end
    end
  end

  // Watchdog looks at the registered request line, so it starts counting the
  // cycle after req_o rises and clears on the accepted grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NCH; c++) begin
        wait_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (!pend_nz[c] || acc[c]) begin
          wait_q[c] <= '0;
        end else if (wait_q[c] != WAIT_LIM) begin
          wait_q[c] <= wait_q[c] + WAIT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_valid_q <= 1'b0;
      disp_id_q    <= '0;
      err_q        <= '0;
    end else begin
      disp_valid_q <= |acc;
      if (|acc) disp_id_q <= acc_id;
      if (err_clr_i) err_q <= err_new;
      else           err_q <= err_q | err_new;
    end
  end

  always_comb begin
    starve_o = '0;
    for (int c = 0; c < NCH; c++) begin
      starve_o[c] = (wait_q[c] == WAIT_LIM);
    end
  end

  assign req_o        = pend_nz;
  assign push_ready_o = ~pend_full;
  assign disp_valid_o = disp_valid_q;
  assign disp_id_o    = disp_id_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_rrb_req_agent.sv
module tb_rrb_req_agent;

  logic       clk;
  logic       rst_n;
  logic [3:0] push;
  logic [3:0] push_ready;
  logic [3:0] req;
  logic [3:0] grant;
  logic       disp_valid;
  logic [1:0] disp_id;
  logic [3:0] starve;
  logic [2:0] err;
  logic       err_clr;

  int checks = 0;
  int fails  = 0;
  int disp_cnt = 0;
  int cyc = 0;
  bit integ = 1'b0;
  logic [31:0] exp_q [$];
  int disp_cyc [$];

  rrb_req_agent #(.CNT_W(3), .WDOG_LIM(12)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_i       (push),
    .push_ready_o (push_ready),
    .req_o        (req),
    .grant_i      (grant),
    .disp_valid_o (disp_valid),
    .disp_id_o    (disp_id),
    .starve_o     (starve),
    .err_o        (err),
    .err_clr_i    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d fails=%0d", checks, fails);
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every dispatch must match the oldest expected channel id.
  always @(negedge clk) begin
    if (disp_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("disp_unexpected", {31'd0, disp_valid}, 32'd0);
      else                   chk("disp_id", {30'd0, disp_id}, exp_q.pop_front());
      disp_cnt++;
      if (integ) disp_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_one(input int c);
    grant = 4'(1 << c);
    exp_q.push_back(32'(c));
    step();
    grant = 4'd0;
    step();
  endtask

  // Behavioural stand-in for rrb: grant on even steps from the request lines,
  // round-robin after the last granted channel, idle cycle in between.
  task automatic run_arb(input int nsteps, inout int rr);
    for (int k = 0; k < nsteps; k++) begin
      grant = 4'd0;
      if ((k % 2) == 0) begin
        for (int i = 1; i <= 4; i++) begin
          int c;
          c = (rr + i) % 4;
          if (grant == 4'd0 && req[c]) begin
            grant = 4'(1 << c);
            exp_q.push_back(32'(c));
            rr = c;
          end
        end
      end
      step();
    end
    grant = 4'd0;
  endtask

  initial begin
    int base;
    int rr;
    rst_n = 1'b0; push = '0; grant = '0; err_clr = 1'b0;
    #1;
    chk("rst_req",   {28'd0, req}, 32'h0);
    chk("rst_ready", {28'd0, push_ready}, 32'hf);
    chk("rst_dv",    {31'd0, disp_valid}, 32'h0);
    chk("rst_id",    {30'd0, disp_id}, 32'h0);
    chk("rst_starve",{28'd0, starve}, 32'h0);
    chk("rst_err",   {29'd0, err}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single request and grant
    push = 4'b0001; step(); push = '0;
    chk("single_req", {28'd0, req}, 32'h1);
    grant = 4'b0001; exp_q.push_back(32'd0); step(); grant = '0;
    chk("single_dv",  {31'd0, disp_valid}, 32'h1);
    chk("single_req_clr", {28'd0, req}, 32'h0);
    step();
    chk("single_dv_drop", {31'd0, disp_valid}, 32'h0);
    chk("single_id_hold", {30'd0, disp_id}, 32'h0);

    // Fill channel 2, then overflow it
    for (int i = 0; i < 8; i++) begin
      push = 4'b0100; step();
      if (i == 5) chk("fill_ready6", {31'd0, push_ready[2]}, 32'h1);
      if (i == 6) begin
        chk("fill_ready7", {31'd0, push_ready[2]}, 32'h0);
        chk("fill_err7",   {29'd0, err}, 32'h0);
      end
    end
    push = '0;
    chk("overflow_err", {29'd0, err}, 32'h1);
    base = disp_cnt;
    for (int i = 0; i < 7; i++) grant_one(2);
    chk("drain2_cnt", 32'(disp_cnt - base), 32'd7);
    chk("drain2_req", {31'd0, req[2]}, 32'h0);
    chk("drain2_err", {29'd0, err}, 32'h1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_err", {29'd0, err}, 32'h0);

    // Push and grant together on a full channel
    for (int i = 0; i < 7; i++) begin push = 4'b0010; step(); end
    push = '0;
    chk("full1_ready", {31'd0, push_ready[1]}, 32'h0);
    push = 4'b0010; grant = 4'b0010; exp_q.push_back(32'd1); step();
    push = '0; grant = '0;
    chk("simul_err",   {29'd0, err}, 32'h0);
    chk("simul_ready", {31'd0, push_ready[1]}, 32'h0);
    step();
    base = disp_cnt;
    for (int i = 0; i < 7; i++) grant_one(1);
    chk("drain1_cnt", 32'(disp_cnt - base), 32'd7);
    chk("drain1_req", {28'd0, req}, 32'h0);
    chk("drain1_err", {29'd0, err}, 32'h0);

    // Bad grants
    grant = 4'b0100; step(); grant = '0; step();
    chk("idle_grant_err", {29'd0, err}, 32'h2);
    push = 4'b0011; step(); push = '0;
    grant = 4'b0011; step(); grant = '0; step();
    chk("multi_grant_err", {29'd0, err}, 32'h6);
    chk("multi_grant_req", {28'd0, req}, 32'h3);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("bad_clr", {29'd0, err}, 32'h0);
    grant_one(0);
    grant_one(1);
    chk("bad_drain_req", {28'd0, req}, 32'h0);
    chk("bad_drain_err", {29'd0, err}, 32'h0);
    err_clr = 1'b1; grant = 4'b1000; step(); err_clr = 1'b0; grant = '0;
    chk("clr_vs_new", {29'd0, err}, 32'h2);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_again", {29'd0, err}, 32'h0);

    // Starvation watchdog on channel 3
    push = 4'b1000; step(); push = '0;
    chk("starve_req", {28'd0, req}, 32'h8);
    chk("starve_0",   {28'd0, starve}, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 11) chk("starve_11", {28'd0, starve}, 32'h0);
      if (i == 12) chk("starve_12", {28'd0, starve}, 32'h8);
    end
    step();
    chk("starve_sat", {28'd0, starve}, 32'h8);
    grant = 4'b1000; exp_q.push_back(32'd3); step(); grant = '0;
    chk("starve_clr", {28'd0, starve}, 32'h0);
    step();

    // Round-robin integration
    push = 4'b1111; step(); step(); push = '0;
    chk("integ_req", {28'd0, req}, 32'hf);
    integ = 1'b1;
    rr = 3;
    base = disp_cnt;
    run_arb(16, rr);
    integ = 1'b0;
    chk("integ_cnt", 32'(disp_cnt - base), 32'd8);
    for (int i = 1; i < disp_cyc.size(); i++)
      chk("integ_spacing", 32'(disp_cyc[i] - disp_cyc[i-1]), 32'd2);
    chk("integ_err", {29'd0, err}, 32'h0);
    chk("integ_req_done", {28'd0, req}, 32'h0);

    // Reset in the middle of a round
    push = 4'b1111; step(); step(); push = '0;
    rr = 3;
    run_arb(7, rr);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_req",    {28'd0, req}, 32'h0);
    chk("mid_rst_ready",  {28'd0, push_ready}, 32'hf);
    chk("mid_rst_dv",     {31'd0, disp_valid}, 32'h0);
    chk("mid_rst_id",     {30'd0, disp_id}, 32'h0);
    chk("mid_rst_starve", {28'd0, starve}, 32'h0);
    chk("mid_rst_err",    {29'd0, err}, 32'h0);
    base = disp_cnt;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_cnt", 32'(disp_cnt - base), 32'd0);
    chk("post_rst_req", {28'd0, req}, 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
